// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: request handshake plus read response.
// The requester drives the master modport and the arbiter receives on the slave modport.
interface sram_port_arbiter_if #(
    parameter int BITS       = 256,
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BITS-1:0]       wdata;
    logic                  rvalid;
    logic [BITS-1:0]       rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter and sequencer for a single-port synchronous SRAM macro.
// Ownership persists for up to BURST_MAX beats under contention, then passes round-robin.
module sram_port_arbiter #(
    parameter int BITS       = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    r0,
    sram_port_arbiter_if.slave    r1,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BITS-1:0]       ram_wd,
    input  logic [BITS-1:0]       ram_rd
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  lp;
    logic                  lp_next;
    logic                  rp;
    logic                  rid;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BITS-1:0]       wd_q;

    logic                  gnt_any;
    logic                  gnt_id;
    logic                  grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BITS-1:0]       sel_wd;

    // The owner keeps the port until its burst is spent and the other side is waiting.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        case (state)
            OWN0: begin
                if (r0.valid && ((cnt < CNT_MAX) || !r1.valid)) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end else if (r1.valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
            end
            OWN1: begin
                if (r1.valid && ((cnt < CNT_MAX) || !r0.valid)) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end else if (r0.valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end
            end
            default: begin
                if (r0.valid && r1.valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = ~lp;
                end else if (r0.valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end else if (r1.valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
            end
        endcase
    end

    // Macro pins and handshakes; rst_n gating drops them the moment reset asserts.
    always_comb begin
        grant     = gnt_any & rst_n;
        sel_we    = gnt_id ? r1.we    : r0.we;
        sel_addr  = gnt_id ? r1.addr  : r0.addr;
        sel_wd    = gnt_id ? r1.wdata : r0.wdata;
        ram_ce    = grant;
        ram_we    = grant & sel_we;
        ram_addr  = grant ? sel_addr : addr_q;
        ram_wd    = grant ? sel_wd   : wd_q;
        r0.ready  = grant & ~gnt_id;
        r1.ready  = grant & gnt_id;
        r0.rvalid = rp & ~rid & rst_n;
        r1.rvalid = rp & rid & rst_n;
        r0.rdata  = ram_rd;
        r1.rdata  = ram_rd;
    end

    always_comb begin
        state_next = IDLE;
        cnt_next   = '0;
        lp_next    = lp;
        if (gnt_any) begin
            state_next = gnt_id ? OWN1 : OWN0;
            lp_next    = gnt_id;
            if (state == (gnt_id ? OWN1 : OWN0)) begin
                cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end else begin
                cnt_next = CNT_W'(1);
            end
        end
    end

    // Last granted address/data are held so idle cycles leave the macro pins quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            lp     <= 1'b1;
            rp     <= 1'b0;
            rid    <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lp    <= lp_next;
            rp    <= gnt_any & ~sel_we;
            if (gnt_any) begin
                rid    <= gnt_id;
                addr_q <= sel_addr;
                wd_q   <= sel_wd;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a behavioural port model.
// A simple registered-read SRAM macro model is attached to the ram_* pins.
module tb_sram_port_arbiter;
    localparam int BITS       = 256;
    localparam int ADDR_WIDTH = 8;
    localparam int BURST_MAX  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  ram_ce;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [BITS-1:0]       ram_wd;
    logic [BITS-1:0]       ram_rd;

    sram_port_arbiter_if #(.BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH)) r0_bus ();
    sram_port_arbiter_if #(.BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH)) r1_bus ();

    sram_port_arbiter #(.BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH), .BURST_MAX(BURST_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0       (r0_bus.slave),
        .r1       (r1_bus.slave),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wd   (ram_wd),
        .ram_rd   (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BITS-1:0] macro_mem [256];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) macro_mem[ram_addr] <= ram_wd;
            else        ram_rd <= macro_mem[ram_addr];
        end
    end

    int checks;
    int failures;
    int obs_grant;

    // Reference: who owns the port, how long it has held it, and one pending read.
    logic [BITS-1:0]       ref_mem [256];
    int                    m_owner;
    int                    m_run;
    int                    m_lp;
    bit                    m_rp;
    int                    m_rid;
    logic [BITS-1:0]       m_rdata;
    logic [ADDR_WIDTH-1:0] m_last_addr;
    logic [BITS-1:0]       m_last_wd;

    task automatic checkOutput(input string tag, input logic [BITS-1:0] observed,
                               input logic [BITS-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_owner     = -1;
        m_run       = 0;
        m_lp        = 1;
        m_rp        = 1'b0;
        m_rid       = 0;
        m_rdata     = '0;
        m_last_addr = '0;
        m_last_wd   = '0;
    endtask

    task automatic applyStimulus(input bit v0, input bit w0, input logic [7:0] a0,
                                 input logic [BITS-1:0] d0,
                                 input bit v1, input bit w1, input logic [7:0] a1,
                                 input logic [BITS-1:0] d1);
        bit                    vv [2];
        bit                    ww [2];
        logic [ADDR_WIDTH-1:0] aa [2];
        logic [BITS-1:0]       dd [2];
        int                    g;
        int                    other;
        logic [ADDR_WIDTH-1:0] exp_addr;
        logic [BITS-1:0]       exp_wd;
        @(negedge clk);
        r0_bus.valid = v0; r0_bus.we = w0; r0_bus.addr = a0; r0_bus.wdata = d0;
        r1_bus.valid = v1; r1_bus.we = w1; r1_bus.addr = a1; r1_bus.wdata = d1;
        vv[0] = v0; vv[1] = v1; ww[0] = w0; ww[1] = w1;
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
        #1;
        obs_grant = r0_bus.ready ? 0 : (r1_bus.ready ? 1 : -1);
        if (!rst_n) begin
            checkOutput("rst_ready0", BITS'(r0_bus.ready), '0);
            checkOutput("rst_ready1", BITS'(r1_bus.ready), '0);
            checkOutput("rst_ce", BITS'(ram_ce), '0);
            checkOutput("rst_we", BITS'(ram_we), '0);
            checkOutput("rst_rvalid0", BITS'(r0_bus.rvalid), '0);
            checkOutput("rst_rvalid1", BITS'(r1_bus.rvalid), '0);
            checkOutput("rst_addr", BITS'(ram_addr), '0);
            return;
        end
        g = -1;
        if (m_owner >= 0) begin
            other = 1 - m_owner;
            if (vv[m_owner] && (m_run < BURST_MAX || !vv[other])) g = m_owner;
            else if (vv[other]) g = other;
        end else begin
            if (v0 && v1) g = 1 - m_lp;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        exp_addr = (g >= 0) ? aa[g] : m_last_addr;
        exp_wd   = (g >= 0) ? dd[g] : m_last_wd;
        checkOutput("ready0", BITS'(r0_bus.ready), BITS'(g == 0));
        checkOutput("ready1", BITS'(r1_bus.ready), BITS'(g == 1));
        checkOutput("ram_ce", BITS'(ram_ce), BITS'(g >= 0));
        checkOutput("ram_we", BITS'(ram_we), BITS'(g >= 0 && ww[g]));
        checkOutput("ram_addr", BITS'(ram_addr), BITS'(exp_addr));
        checkOutput("ram_wd", ram_wd, exp_wd);
        checkOutput("rvalid0", BITS'(r0_bus.rvalid), BITS'(m_rp && m_rid == 0));
        checkOutput("rvalid1", BITS'(r1_bus.rvalid), BITS'(m_rp && m_rid == 1));
        if (m_rp) checkOutput("rdata", (m_rid == 0) ? r0_bus.rdata : r1_bus.rdata, m_rdata);
        m_rp = 1'b0;
        if (g >= 0) begin
            m_run       = (g == m_owner) ? ((m_run < BURST_MAX) ? m_run + 1 : m_run) : 1;
            m_owner     = g;
            m_lp        = g;
            m_last_addr = aa[g];
            m_last_wd   = dd[g];
            if (ww[g]) begin
                ref_mem[aa[g]] = dd[g];
            end else begin
                m_rp    = 1'b1;
                m_rid   = g;
                m_rdata = ref_mem[aa[g]];
            end
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 8'h00, '0, 0, 0, 8'h00, '0);
    endtask

    logic [BITS-1:0] pat_a5;
    logic [BITS-1:0] d3;
    logic [BITS-1:0] d7;
    int              burst_exp [12];

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            macro_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        burst_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        pat_a5    = {32{8'hA5}};
        d3        = {8{$urandom()}};
        d7        = {8{$urandom()}};
        modelReset();

        rst_n = 1'b0;
        applyStimulus(1, 0, 8'h21, '0, 1, 0, 8'h42, '0);
        applyStimulus(1, 0, 8'h21, '0, 1, 0, 8'h42, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1, 0, 8'h21, '0, 1, 0, 8'h42, '0);
        checkOutput("first_ready0", BITS'(r0_bus.ready), BITS'(1));
        checkOutput("first_addr", BITS'(ram_addr), BITS'(8'h21));
        idleCycle();

        applyStimulus(1, 1, 8'h10, pat_a5, 0, 0, 8'h00, '0);
        applyStimulus(1, 0, 8'h10, '0, 0, 0, 8'h00, '0);
        idleCycle();
        checkOutput("single_rvalid0", BITS'(r0_bus.rvalid), BITS'(1));
        checkOutput("single_rdata", r0_bus.rdata, pat_a5);
        checkOutput("single_rvalid1", BITS'(r1_bus.rvalid), '0);
        idleCycle();
        checkOutput("single_pulse", BITS'(r0_bus.rvalid), '0);

        applyStimulus(0, 0, 8'h00, '0, 1, 1, 8'h50, {8{$urandom()}});
        idleCycle();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 8'($urandom_range(0, 255)), '0, 1, 0, 8'($urandom_range(0, 255)), '0);
            checkOutput($sformatf("burst%0d", i), BITS'(obs_grant), BITS'(burst_exp[i]));
        end
        idleCycle();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 8'h00, '0, 1, 0, 8'(i), '0);
            checkOutput($sformatf("solo%0d", i), BITS'(obs_grant), BITS'(1));
        end
        applyStimulus(1, 0, 8'h05, '0, 1, 0, 8'h0A, '0);
        checkOutput("solo_handover", BITS'(obs_grant), BITS'(0));
        idleCycle();

        applyStimulus(1, 1, 8'h03, d3, 0, 0, 8'h00, '0);
        applyStimulus(0, 0, 8'h00, '0, 1, 1, 8'h07, d7);
        idleCycle();
        applyStimulus(1, 0, 8'h03, '0, 0, 0, 8'h00, '0);
        applyStimulus(0, 0, 8'h00, '0, 1, 0, 8'h07, '0);
        checkOutput("alt_rvalid0", BITS'(r0_bus.rvalid), BITS'(1));
        checkOutput("alt_rdata0", r0_bus.rdata, d3);
        idleCycle();
        checkOutput("alt_rvalid1", BITS'(r1_bus.rvalid), BITS'(1));
        checkOutput("alt_rdata1", r1_bus.rdata, d7);
        checkOutput("alt_rvalid0_off", BITS'(r0_bus.rvalid), '0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 8'(8'h30 + i), {8{$urandom()}}, 0, 0, 8'h00, '0);
        end
        idleCycle();
        checkOutput("idle_ce", BITS'(ram_ce), '0);
        checkOutput("idle_addr_hold", BITS'(ram_addr), BITS'(8'h32));

        applyStimulus(1, 0, 8'h10, '0, 0, 0, 8'h00, '0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        r0_bus.valid = 1'b0;
        #1;
        checkOutput("midrst_rvalid0", BITS'(r0_bus.rvalid), '0);
        checkOutput("midrst_ce", BITS'(ram_ce), '0);
        modelReset();
        idleCycle();
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), {8{$urandom()}},
                          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), {8{$urandom()}});
        end
        idleCycle();
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
